// File: rtl/tone_arbiter_if.sv
// Bundle between the music mux / game logic and the tone arbiter.
// master: request and music side; slave: the arbiter itself.
interface tone_arbiter_if;
    logic [31:0] freq_music;
    logic        req_hit;
    logic        req_kill;
    logic        req_boss;
    logic        mute;
    logic [31:0] freq;
    logic        sfx_active;
    logic [1:0]  sfx_id;

    modport master (
        output freq_music, req_hit, req_kill, req_boss, mute,
        input  freq, sfx_active, sfx_id
    );

    modport slave (
        input  freq_music, req_hit, req_kill, req_boss, mute,
        output freq, sfx_active, sfx_id
    );
endinterface

// File: rtl/tone_arbiter.sv
// tone_arbiter: shares the single tone generator between background music
// and three one-shot effects (player hit > enemy kill > boss hit).
// Requests are sampled once, rising edges are latched as pending, and the
// highest-priority source gets the generator for LEN duration ticks.
// Optional build macro TONE_ARB_VIBRATO_EN: the effect pitch jumps an octave
// on alternate ticks.
//
// state | meaning
// IDLE  | music owns the generator, waiting for an edge or pending bit
// PLAY  | effect sfx_id owns the generator, dur ticks remaining
module tone_arbiter #(
    parameter int          TICK_DIV  = 1_000_000,
    parameter int          HIT_LEN   = 30,
    parameter int          KILL_LEN  = 15,
    parameter int          BOSS_LEN  = 8,
    parameter logic [31:0] HIT_FREQ  = 32'd196,
    parameter logic [31:0] KILL_FREQ = 32'd1047,
    parameter logic [31:0] BOSS_FREQ = 32'd659
) (
    input  logic         clk,
    input  logic         rst,
    tone_arbiter_if.slave bus
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    // Source vectors are ordered {hit, kill, boss}, so ids 3/2/1 map to bits 2/1/0
    // and a numerically larger id is always the higher priority.
    logic [2:0]    req_s_q, req_prev_q, req_edge;
    logic [2:0]    pend_q, pend_d;
    state_t        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    dur_q, dur_d;
    logic [31:0]   freq_q;
    logic          active_q;
    logic          tick;
    logic          grant;
    logic [1:0]    gnt_id;
    logic [1:0]    edge_top, any_top;
    logic [31:0]   eff_freq;

    function automatic logic [1:0] top_id(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [7:0] len_of(input logic [1:0] id);
        case (id)
            2'd3:    return 8'(HIT_LEN);
            2'd2:    return 8'(KILL_LEN);
            2'd1:    return 8'(BOSS_LEN);
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [31:0] freq_of(input logic [1:0] id);
        case (id)
            2'd3:    return HIT_FREQ;
            2'd2:    return KILL_FREQ;
            2'd1:    return BOSS_FREQ;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] mask_of(input logic [1:0] id);
        case (id)
            2'd3:    return 3'b100;
            2'd2:    return 3'b010;
            2'd1:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign req_edge = req_s_q & ~req_prev_q;
    assign tick     = (presc_q == PRESC_LAST);
    assign edge_top = top_id(req_edge);
    assign any_top  = top_id(pend_q | req_edge);

`ifdef TONE_ARB_VIBRATO_EN
    logic oct_q, oct_d;
    assign eff_freq = oct_q ? (freq_of(id_q) << 1) : freq_of(id_q);
`else
    assign eff_freq = freq_of(id_q);
`endif

    // Sample requests and keep the previous sample for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s_q    <= 3'b000;
            req_prev_q <= 3'b000;
        end else begin
            req_s_q    <= {bus.req_hit, bus.req_kill, bus.req_boss};
            req_prev_q <= req_s_q;
        end
    end

    // Arbiter state, pending bits and effect timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 2'd0;
            pend_q  <= 3'b000;
            presc_q <= '0;
            dur_q   <= 8'd0;
`ifdef TONE_ARB_VIBRATO_EN
            oct_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
`ifdef TONE_ARB_VIBRATO_EN
            oct_q   <= oct_d;
`endif
        end
    end

    // Grant selection: preempt/retrigger first, then normal expiry hand-over.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pend_d  = pend_q | req_edge;
        presc_d = presc_q;
        dur_d   = dur_q;
        grant   = 1'b0;
        gnt_id  = 2'd0;
`ifdef TONE_ARB_VIBRATO_EN
        oct_d   = oct_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_top != 2'd0) begin
                    grant  = 1'b1;
                    gnt_id = any_top;
                end
            end
            PLAY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
`ifdef TONE_ARB_VIBRATO_EN
                if (tick) oct_d = ~oct_q;
`endif
                // An edge from the current source (retrigger) or a higher one wins outright.
                if (edge_top != 2'd0 && edge_top >= id_q) begin
                    grant  = 1'b1;
                    gnt_id = edge_top;
                end else if (tick) begin
                    if (dur_q == 8'd1) begin
                        if (any_top != 2'd0) begin
                            grant  = 1'b1;
                            gnt_id = any_top;
                        end else begin
                            state_d = IDLE;
                            id_d    = 2'd0;
                        end
                    end else begin
                        dur_d = dur_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = 2'd0;
            end
        endcase

        if (grant) begin
            state_d = PLAY;
            id_d    = gnt_id;
            dur_d   = len_of(gnt_id);
            presc_d = '0;
            pend_d  = pend_d & ~mask_of(gnt_id);
`ifdef TONE_ARB_VIBRATO_EN
            oct_d   = 1'b0;
`endif
        end
    end

    // Registered tone output, one cycle behind the arbiter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_q   <= 32'd0;
            active_q <= 1'b0;
        end else begin
            if (bus.mute)
                freq_q <= 32'd0;
            else if (state_q == PLAY)
                freq_q <= eff_freq;
            else
                freq_q <= bus.freq_music;
            active_q <= (state_q == PLAY);
        end
    end

    assign bus.freq       = freq_q;
    assign bus.sfx_active = active_q;
    assign bus.sfx_id     = id_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Testbench for tone_arbiter with short ticks (TICK_DIV=4) and short effects.
// Segment table drives inputs per cycle; expected outputs go through a
// scoreboard queue and are compared one clock later, after the active edge.
module tb_tone_arbiter;

`ifdef TONE_ARB_VIBRATO_EN
    localparam bit VIB = 1'b1;
`else
    localparam bit VIB = 1'b0;
`endif

    typedef struct {
        logic        hit, kill, boss, mute;
        logic [31:0] music;
        int          n;
        logic [31:0] ef;
        logic        ea;
        logic [1:0]  eid;
    } vec_t;

    typedef struct {
        logic [31:0] f;
        logic        a;
        logic [1:0]  id;
        int          seg;
    } exp_t;

    logic clk;
    logic rst;
    tone_arbiter_if bus();

    tone_arbiter #(
        .TICK_DIV (4),
        .HIT_LEN  (3),
        .KILL_LEN (2),
        .BOSS_LEN (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic h, input logic k, input logic b, input logic m,
                                input logic [31:0] mus, input int n,
                                input logic [31:0] ef, input logic ea, input logic [1:0] eid);
        vec_t v;
        v.hit = h; v.kill = k; v.boss = b; v.mute = m; v.music = mus;
        v.n = n; v.ef = ef; v.ea = ea; v.eid = eid;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int seg, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s seg=%0d t=%0t got=%0d expected=%0d", name, seg, $time, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] f2;
        exp_t e;
        f2 = VIB ? 32'd392 : 32'd196;

        // A: basic hit, held high, must fire only once
        add(0,0,0,0,440, 3, 440,   0,0);
        add(1,0,0,0,440, 1, 440,   0,0);
        add(1,0,0,0,440, 1, 440,   0,3);
        add(1,0,0,0,440, 4, 196,   1,3);
        add(1,0,0,0,440, 4, f2,    1,3);
        add(1,0,0,0,440, 3, 196,   1,3);
        add(1,0,0,0,440, 1, 196,   1,0);
        add(1,0,0,0,440, 6, 440,   0,0);
        add(0,0,0,0,440, 2, 440,   0,0);
        // D: retrigger while muted, output silent, timing unchanged
        add(0,0,0,1,440, 2, 0,     0,0);
        add(1,0,0,1,440, 1, 0,     0,0);
        add(1,0,0,1,440, 1, 0,     0,3);
        add(1,0,0,1,440, 1, 0,     1,3);
        add(0,0,0,1,440, 5, 0,     1,3);
        add(1,0,0,1,440, 13, 0,    1,3);
        add(1,0,0,1,440, 1, 0,     1,0);
        add(1,0,0,1,440, 2, 0,     0,0);
        add(0,0,0,0,440, 2, 440,   0,0);
        // music pass-through
        add(0,0,0,0,523, 1, 523,   0,0);
        add(0,0,0,0,0,   1, 0,     0,0);
        add(0,0,0,0,440, 2, 440,   0,0);
        if (!VIB) begin
            // B: simultaneous kill+boss, back to back
            add(0,1,1,0,440, 1, 440,  0,0);
            add(0,1,1,0,440, 1, 440,  0,2);
            add(0,1,1,0,440, 7, 1047, 1,2);
            add(0,1,1,0,440, 1, 1047, 1,1);
            add(0,1,1,0,440, 3, 659,  1,1);
            add(0,1,1,0,440, 1, 659,  1,0);
            add(0,1,1,0,440, 3, 440,  0,0);
            add(0,0,0,0,440, 2, 440,  0,0);
            // C: hit preempts boss, boss discarded
            add(0,0,1,0,440, 1, 440,  0,0);
            add(0,0,1,0,440, 1, 440,  0,1);
            add(1,0,1,0,440, 1, 659,  1,1);
            add(1,0,1,0,440, 1, 659,  1,3);
            add(1,0,1,0,440, 11, 196, 1,3);
            add(1,0,1,0,440, 1, 196,  1,0);
            add(1,0,1,0,440, 3, 440,  0,0);
            add(0,0,0,0,440, 2, 440,  0,0);
            // E: kill during hit waits, then follows with no gap
            add(1,0,0,0,440, 1, 440,  0,0);
            add(1,0,0,0,440, 1, 440,  0,3);
            add(1,0,0,0,440, 2, 196,  1,3);
            add(1,1,0,0,440, 9, 196,  1,3);
            add(1,1,0,0,440, 1, 196,  1,2);
            add(1,1,0,0,440, 7, 1047, 1,2);
            add(1,1,0,0,440, 1, 1047, 1,0);
            add(1,1,0,0,440, 2, 440,  0,0);
            add(0,0,0,0,440, 2, 440,  0,0);
        end

        rst = 1'b1;
        bus.req_hit = 1'b0; bus.req_kill = 1'b0; bus.req_boss = 1'b0;
        bus.mute = 1'b0; bus.freq_music = 32'd440;
        repeat (3) @(posedge clk);
        #1;
        check("reset_freq",   -1, bus.freq, 32'd0);
        check("reset_active", -1, 32'(bus.sfx_active), 32'd0);
        check("reset_id",     -1, 32'(bus.sfx_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                @(negedge clk);
                bus.req_hit    = vecs[i].hit;
                bus.req_kill   = vecs[i].kill;
                bus.req_boss   = vecs[i].boss;
                bus.mute       = vecs[i].mute;
                bus.freq_music = vecs[i].music;
                e.f = vecs[i].ef; e.a = vecs[i].ea; e.id = vecs[i].eid; e.seg = i;
                sb.push_back(e);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check("freq",       e.seg, bus.freq, e.f);
                check("sfx_active", e.seg, 32'(bus.sfx_active), 32'(e.a));
                check("sfx_id",     e.seg, 32'(bus.sfx_id), 32'(e.id));
            end
        end

        // Async reset in the middle of a kill effect
        @(negedge clk);
        bus.req_kill = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("kill_before_rst_freq", -2, bus.freq, 32'd1047);
        check("kill_before_rst_id",   -2, 32'(bus.sfx_id), 32'd2);
        #2;
        rst = 1'b1;
        bus.req_kill = 1'b0;
        #1;
        check("async_rst_freq",   -2, bus.freq, 32'd0);
        check("async_rst_active", -2, 32'(bus.sfx_active), 32'd0);
        check("async_rst_id",     -2, 32'(bus.sfx_id), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_freq",   -3, bus.freq, 32'd440);
        check("post_rst_active", -3, 32'(bus.sfx_active), 32'd0);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_hold_freq", -3, bus.freq, 32'd440);
            check("post_rst_hold_id",   -3, 32'(bus.sfx_id), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares the single tone generator (PWM_gen toneGen) between the background-music frequency and three one-shot sound effects: player hit, enemy kill and boss hit.
- Sits between the music Mux output and toneGen.freq; runs on the 100 MHz system clock.
- Detects effect requests, arbitrates them by fixed priority and times each effect.
- Drives either the effect tone or the music tone to the generator.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per duration tick (10 ms at 100 MHz).
- HIT_LEN, 30: player-hit effect length in ticks (1..255).
- KILL_LEN, 15: enemy-kill effect length in ticks (1..255).
- BOSS_LEN, 8: boss-hit effect length in ticks (1..255).
- HIT_FREQ, 32'd196: player-hit tone in Hz.
- KILL_FREQ, 32'd1047: enemy-kill tone in Hz.
- BOSS_FREQ, 32'd659: boss-hit tone in Hz.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- freq_music  in  32  background-music frequency in Hz (0 = silence).
- req_hit  in  1  player-hit request, level; rising edge triggers.
- req_kill  in  1  enemy-kill request, level; rising edge triggers.
- req_boss  in  1  boss-hit request, level; rising edge triggers.
- mute  in  1  forces the output to silence.
- freq  out  32  frequency to the tone generator in Hz, registered.
- sfx_active  out  1  an effect currently owns the generator.
- sfx_id  out  2  current owner: 0 music, 1 boss, 2 kill, 3 hit.

Behaviour:
- Reset (async, rst=1): freq=0, sfx_active=0, sfx_id=0, state IDLE.
  - Pending bits, edge-detect registers, prescaler and duration counter all cleared.
  - Reset mid-effect aborts it immediately; no request is remembered across reset.
- Edge detect:
  - One prev register per request; an edge is req=1 & prev=0 at a clk edge.
  - A held-high request fires once only.
- Pending:
  - An edge sets that source's pending bit.
  - The bit is cleared when the source is granted.
  - Edges arriving while the bit is already set are merged.
- Priority: hit > kill > boss.
- IDLE: on any pending bit or same-cycle edge, grant the highest at that edge.
  - State goes to PLAY, sfx_id is set, dur is loaded with that source's LEN and the prescaler is cleared.
- PLAY timing:
  - Prescaler counts 0..TICK_DIV-1; tick = prescaler wraps.
  - dur decrements on tick.
  - On a tick with dur==1 the effect ends, so an effect lasts exactly LEN*TICK_DIV cycles.
- PLAY, effect ends:
  - If any pending bit is set, the highest pending is granted at the same edge; there is no music gap.
  - Otherwise the state returns to IDLE.
- Preemption:
  - An edge from a strictly higher-priority source during PLAY grants it at that edge.
  - The preempted effect is discarded, not resumed.
- Retrigger: an edge from the currently playing source reloads dur and clears the prescaler (effect restarts).
- Lower priority during PLAY: the edge only sets the pending bit; it is served after the current effect ends.
- Simultaneous edges: the highest is granted; the others go pending.
- Output register (1 cycle after the state/sfx_id update):
  - mute=1: freq=0.
  - PLAY: freq = the source's FREQ.
  - IDLE: freq = freq_music.
  - sfx_active = (state==PLAY).
  - Overall latency is 2 clk from the first sampled request edge to freq changing.
- mute does not affect arbitration or timing; effects still run and expire silently.
- freq_music changes pass through with 1 cycle latency while IDLE.

Optional Feature:
- Macro TONE_ARB_VIBRATO_EN.
- Defined: while in PLAY, an octave flag toggles on every tick and is cleared on every grant.
  - freq = FREQ<<1 when the flag is set, FREQ otherwise.
  - The effect starts at base pitch.
- Undefined: effect pitch is constant FREQ and no flag register exists.
- All timing is identical in both builds.

Test Plan:
- Bench params: TICK_DIV=4, HIT_LEN=3, KILL_LEN=2, BOSS_LEN=1.
- Basic hit: freq_music=440, req_hit rises at cycle 10 and is held high.
  - freq=196 and sfx_id=3 from cycle 12 for exactly 12 cycles, then freq=440 and sfx_id=0.
  - No second effect fires while req_hit stays high.
- Simultaneous requests: req_boss and req_kill rise in the same cycle.
  - Kill plays for 8 cycles (freq 1047), then boss for 4 cycles (freq 659) back-to-back.
  - freq then returns to music; freq never shows 440 between the two effects.
- Preemption: boss playing, req_hit edge 2 cycles into it.
  - freq=196 two cycles after the edge and lasts 12 cycles.
  - Boss is not resumed; sfx_id goes 1→3→0.
- Retrigger and mute: hit playing, a second req_hit edge at tick 2 extends the effect to 12 cycles after the retrigger.
  - With mute=1 the whole time: freq=0 throughout while sfx_active follows the same timing.
- Async reset: assert rst mid-kill, asynchronously between clk edges.
  - freq=0, sfx_active=0 and sfx_id=0 immediately.
  - After release with req inputs low, freq=freq_music after 1 cycle and no effect plays.
- Vibrato build (TONE_ARB_VIBRATO_EN): hit effect outputs freq 196,392,196 per 4-cycle tick.
